instruction_fetch: RTL and testbench

Instruction fetch stage and IF/ID pipeline register for the MIPS datapath. It holds the program counter, drives the instruction-memory address, and captures the returned word into the IF/ID register. It also presents the opcode field `op` that `control_unit` decodes on the following falling edge. It sits upstream of `control_unit`, the register file and the sign extender, and it takes branch redirects back from the EX/MEM stage.

---
 rtl/mips_pkg.sv | 18 +
 rtl/if_id_reg.sv | 31 +++
 rtl/instruction_fetch.sv | 96 +++++++++
 tb/tb_instruction_fetch.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath constants, opcodes and fetch-state type
package mips_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetchState_e;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - pipeline stage register with hold and bubble-inject controls
module if_id_reg
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic [WIDTH-1:0] instrIn,
  input  logic [WIDTH-1:0] pc4In,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] pc4,
  output logic             valid
);

  // Reset and flush both leave a bubble; flush overrides hold.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instr <= WIDTH'(NOP_INSTR);
      pc4   <= '0;
      valid <= 1'b0;
    end else if (!hold) begin
      instr <= instrIn;
      pc4   <= pc4In;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC, fetch FSM, fetch counter and IF/ID register
module instruction_fetch
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  op,
  output logic [31:0] fetch_count,
  output logic        misalign_err
);

  fetchState_e state;
  fetchState_e stateNext;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] fetchCount;
  logic        misalignErr;
  logic        advance;
  logic        flush;

  assign pcPlus4 = pc + 32'd4;

  // A branch always wins over stall; otherwise a non-stalled edge advances.
  always_comb begin
    stateNext = state;
    advance   = 1'b0;
    flush     = 1'b0;
    if (branch_taken) begin
      flush     = 1'b1;
      stateNext = FLUSH;
    end else if (!stall) begin
      advance   = 1'b1;
      stateNext = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (flush) begin
      pc <= {branch_target[31:2], 2'b00};
    end else if (advance) begin
      pc <= pcPlus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchCount <= '0;
    end else if (advance) begin
      fetchCount <= fetchCount + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalignErr <= 1'b0;
    end else if (flush && (branch_target[1:0] != 2'b00)) begin
      misalignErr <= 1'b1;
    end
  end

  if_id_reg #(.WIDTH(32)) ifIdReg (
    .clk     (clk),
    .rst     (rst),
    .hold    (!advance),
    .flush   (flush),
    .instrIn (imem_rdata),
    .pc4In   (pcPlus4),
    .instr   (if_id_instr),
    .pc4     (if_id_pc4),
    .valid   (if_id_valid)
  );

  assign imem_addr    = pc;
  assign op           = if_id_instr[31:26];
  assign fetch_count  = fetchCount;
  assign misalign_err = misalignErr;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - table-driven directed bench for instruction_fetch
module tb_instruction_fetch;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  op;
  logic [31:0] fetch_count;
  logic        misalign_err;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  // Instruction memory model: every word is its own address tagged with A5A5.
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  instruction_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .op            (op),
    .fetch_count   (fetch_count),
    .misalign_err  (misalign_err)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] cnt;
    logic        mis;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] expInstr;
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         32'h0,  1'b0, 32'd0, 1'b0, BOOT};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         32'h0,  1'b0, 32'd0, 1'b0, BOOT};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         32'h0,         32'h0,  1'b0, 32'd0, 1'b0, BOOT};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         32'hA5A5_0000, 32'h4,  1'b1, 32'd1, 1'b0, RUN};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h8,         32'hA5A5_0004, 32'h8,  1'b1, 32'd2, 1'b0, RUN};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hC,         32'hA5A5_0008, 32'hC,  1'b1, 32'd3, 1'b0, RUN};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h10,        32'hA5A5_000C, 32'h10, 1'b1, 32'd4, 1'b0, RUN};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h10,        32'hA5A5_000C, 32'h10, 1'b1, 32'd4, 1'b0, RUN};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h10,        32'hA5A5_000C, 32'h10, 1'b1, 32'd4, 1'b0, RUN};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h10,        32'hA5A5_000C, 32'h10, 1'b1, 32'd4, 1'b0, RUN};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h14,        32'hA5A5_0010, 32'h14, 1'b1, 32'd5, 1'b0, RUN};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h40,        32'h40,        32'h0,         32'h0,  1'b0, 32'd5, 1'b0, FLUSH};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h44,        32'hA5A5_0040, 32'h44, 1'b1, 32'd6, 1'b0, RUN};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h43,        32'h40,        32'h0,         32'h0,  1'b0, 32'd6, 1'b1, FLUSH};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h80,        32'h80,        32'h0,         32'h0,  1'b0, 32'd6, 1'b1, FLUSH};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h84,        32'hA5A5_0080, 32'h84, 1'b1, 32'd7, 1'b1, RUN};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         32'h0,  1'b0, 32'd7, 1'b1, FLUSH};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h5A5A_FFFC, 32'h0,  1'b1, 32'd8, 1'b1, RUN};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         32'h0,  1'b0, 32'd0, 1'b0, BOOT};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         32'hA5A5_0000, 32'h4,  1'b1, 32'd1, 1'b0, RUN};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 32'h20,        32'h20,        32'h0,         32'h0,  1'b0, 32'd1, 1'b0, FLUSH};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h20,        32'h0,         32'h0,  1'b0, 32'd1, 1'b0, FLUSH};
    vecs[22] = '{1'b1, 1'b1, 1'b1, 32'h43,        32'h0,         32'h0,         32'h0,  1'b0, 32'd0, 1'b0, BOOT};

    rst = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    #2;

    for (int i = 0; i < 23; i++) begin
      rst           = vecs[i].rst;
      stall         = vecs[i].stall;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].tgt;
      @(posedge clk);
      #1;
      expInstr = vecs[i].instr;
      chk($sformatf("v%0d imem_addr", i),    imem_addr,              vecs[i].addr);
      chk($sformatf("v%0d if_id_instr", i),  if_id_instr,            vecs[i].instr);
      chk($sformatf("v%0d op", i),           {26'd0, op},            {26'd0, expInstr[31:26]});
      chk($sformatf("v%0d if_id_pc4", i),    if_id_pc4,              vecs[i].pc4);
      chk($sformatf("v%0d if_id_valid", i),  {31'd0, if_id_valid},   {31'd0, vecs[i].valid});
      chk($sformatf("v%0d fetch_count", i),  fetch_count,            vecs[i].cnt);
      chk($sformatf("v%0d misalign_err", i), {31'd0, misalign_err},  {31'd0, vecs[i].mis});
      chk($sformatf("v%0d state", i),        {30'd0, dut.state},     {30'd0, vecs[i].st});
    end

    // Counter wrap: preload all-ones, then one normal advance.
    rst = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    #2;
    force dut.fetchCount = 32'hFFFF_FFFF;
    #1;
    release dut.fetchCount;
    #1;
    chk("wrap preload", fetch_count, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    chk("wrap fetch_count", fetch_count, 32'h0);
    chk("wrap imem_addr", imem_addr, 32'h4);
    chk("wrap if_id_valid", {31'd0, if_id_valid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
